// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port round-robin arbiter for an asynchronous SRAM
//
// Purpose:
//   Serialises read and write requests from two ports (P0 = CPU, P1 = loader/
//   debug) onto one asynchronous 16-bit SRAM. Strobe widths are set by
//   READ_WAIT / WRITE_WAIT, and every SRAM-facing output comes from a flop.
//
// Ports:
//   Clk, Reset_n          clock; asynchronous active-low reset
//   Px_Req                request, held by the port until its Px_Ack
//   Px_WE                 1 = write, 0 = read
//   Px_Addr               word address
//   Px_WData              write data
//   Px_BE                 byte enables (bit1 = upper, bit0 = lower)
//   Px_Ack                one-cycle completion pulse
//   Px_RData              last read data of that port
//   Busy                  high whenever the controller is not idle
//   CE, OE, WE, LB, UB    active-low SRAM strobes
//   ADDR                  SRAM address
//   DQ                    SRAM data bus; driven only during write phases

module sram_arbiter #(
  parameter int unsigned READ_WAIT  = 1,
  parameter int unsigned WRITE_WAIT = 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        P0_Req,
  input  logic        P0_WE,
  input  logic [19:0] P0_Addr,
  input  logic [15:0] P0_WData,
  input  logic [1:0]  P0_BE,
  output logic        P0_Ack,
  output logic [15:0] P0_RData,
  input  logic        P1_Req,
  input  logic        P1_WE,
  input  logic [19:0] P1_Addr,
  input  logic [15:0] P1_WData,
  input  logic [1:0]  P1_BE,
  output logic        P1_Ack,
  output logic [15:0] P1_RData,
  output logic        Busy,
  output logic        CE,
  output logic        OE,
  output logic        WE,
  output logic        LB,
  output logic        UB,
  output logic [19:0] ADDR,
  inout  wire  [15:0] DQ
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } state_t;

  // The down-counter runs from the load value to zero, so a phase lasts
  // load+1 cycles.
  localparam logic [3:0] RD_LOAD = 4'(READ_WAIT);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_WAIT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        grant_q, grant_d;   // port being served (0 = P0, 1 = P1)
  logic        prio_q, prio_d;     // port that wins the next simultaneous request
  logic        we_q, we_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic        ce_q, ce_d;
  logic        oe_q, oe_d;
  logic        we_n_q, we_n_d;
  logic        lb_q, lb_d;
  logic        ub_q, ub_d;
  logic        dq_oe_q, dq_oe_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;
  logic        busy_q, busy_d;
  logic        sel;
  logic        req_held;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    prio_d   = prio_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    sel      = 1'b0;
    // A port that dropped its request mid-transaction still gets serviced,
    // it just does not see the Ack.
    req_held = grant_q ? P1_Req : P0_Req;

    unique case (state_q)
      S_IDLE: begin
        if (P0_Req || P1_Req) begin
          sel     = (P0_Req && P1_Req) ? prio_q : P1_Req;
          grant_d = sel;
          prio_d  = ~sel;
          we_d    = sel ? P1_WE    : P0_WE;
          addr_d  = sel ? P1_Addr  : P0_Addr;
          wdata_d = sel ? P1_WData : P0_WData;
          be_d    = sel ? P1_BE    : P0_BE;
          cnt_d   = RD_LOAD;
          state_d = we_d ? S_WR_SETUP : S_RD;
        end
      end
      S_RD: begin
        if (cnt_q == 4'd0) begin
          // Data is captured on the last strobe cycle, so RData is valid
          // in the same cycle as the Ack.
          if (grant_q) begin
            rdata1_d = DQ;
          end else begin
            rdata0_d = DQ;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR_SETUP: begin
        cnt_d   = WR_LOAD;
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR_HOLD: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        // Always pass through IDLE so a busy port cannot starve the other.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_DONE) begin
      ack0_d = ~grant_q & req_held;
      ack1_d = grant_q & req_held;
    end

    // Strobes are decoded from the next state so the registered outputs line
    // up exactly with the state they belong to.
    ce_d    = 1'b1;
    oe_d    = 1'b1;
    we_n_d  = 1'b1;
    lb_d    = 1'b1;
    ub_d    = 1'b1;
    dq_oe_d = 1'b0;
    case (state_d)
      S_RD: begin
        ce_d = 1'b0;
        oe_d = 1'b0;
        lb_d = ~be_d[0];
        ub_d = ~be_d[1];
      end
      S_WR_SETUP, S_WR_HOLD: begin
        ce_d    = 1'b0;
        lb_d    = ~be_d[0];
        ub_d    = ~be_d[1];
        dq_oe_d = 1'b1;
      end
      S_WR_PULSE: begin
        ce_d    = 1'b0;
        we_n_d  = 1'b0;
        lb_d    = ~be_d[0];
        ub_d    = ~be_d[1];
        dq_oe_d = 1'b1;
      end
      default: begin
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      grant_q  <= 1'b0;
      prio_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 20'd0;
      wdata_q  <= 16'd0;
      be_q     <= 2'd0;
      ce_q     <= 1'b1;
      oe_q     <= 1'b1;
      we_n_q   <= 1'b1;
      lb_q     <= 1'b1;
      ub_q     <= 1'b1;
      dq_oe_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= 16'd0;
      rdata1_q <= 16'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      prio_q   <= prio_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      ce_q     <= ce_d;
      oe_q     <= oe_d;
      we_n_q   <= we_n_d;
      lb_q     <= lb_d;
      ub_q     <= ub_d;
      dq_oe_q  <= dq_oe_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      busy_q   <= busy_d;
    end
  end

  assign DQ       = dq_oe_q ? wdata_q : 16'bz;
  assign ADDR     = addr_q;
  assign CE       = ce_q;
  assign OE       = oe_q;
  assign WE       = we_n_q;
  assign LB       = lb_q;
  assign UB       = ub_q;
  assign Busy     = busy_q;
  assign P0_Ack   = ack0_q;
  assign P1_Ack   = ack1_q;
  assign P0_RData = rdata0_q;
  assign P1_RData = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter

module tb_sram_arbiter;

  localparam int RW     = 1;
  localparam int WW     = 1;
  localparam int LAT_RD = RW + 3;
  localparam int LAT_WR = WW + 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req     [2];
  logic        we_i    [2];
  logic [19:0] addr_i  [2];
  logic [15:0] wdata_i [2];
  logic [1:0]  be_i    [2];
  logic        ack     [2];
  logic [15:0] rdata   [2];
  logic        Busy, CE, OE, WE, LB, UB;
  logic [19:0] ADDR;
  wire  [15:0] dq;

  sram_arbiter #(.READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .Clk(clk), .Reset_n(rst_n),
    .P0_Req(req[0]), .P0_WE(we_i[0]), .P0_Addr(addr_i[0]), .P0_WData(wdata_i[0]),
    .P0_BE(be_i[0]), .P0_Ack(ack[0]), .P0_RData(rdata[0]),
    .P1_Req(req[1]), .P1_WE(we_i[1]), .P1_Addr(addr_i[1]), .P1_WData(wdata_i[1]),
    .P1_BE(be_i[1]), .P1_Ack(ack[1]), .P1_RData(rdata[1]),
    .Busy(Busy), .CE(CE), .OE(OE), .WE(WE), .LB(LB), .UB(UB),
    .ADDR(ADDR), .DQ(dq)
  );

  always #5 clk = ~clk;

  // SRAM model: a weak pull-down makes an undriven bus read as zero.
  logic [15:0] mem [1024];
  logic        mem_clr = 1'b0;
  logic        pre_en  = 1'b0;
  logic [9:0]  pre_addr;
  logic [15:0] pre_data;

  for (genvar i = 0; i < 16; i++) begin : g_pd
    pulldown (dq[i]);
  end

  assign dq = (!CE && !OE && WE) ? mem[ADDR[9:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0;
    end else if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (!CE && !WE) begin
      if (!LB) mem[ADDR[9:0]][7:0]  <= dq[7:0];
      if (!UB) mem[ADDR[9:0]][15:8] <= dq[15:8];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference state kept at transaction level.
  logic [15:0] ref_mem [1024];
  int          rr_next;
  logic [15:0] last_rd [2];
  bit          have_rd [2];
  logic        t_we    [2];
  logic [19:0] t_addr  [2];
  logic [15:0] t_wdata [2];
  logic [1:0]  t_be    [2];
  int          oe_lo, we_lo;
  logic [1:0]  strobes_we;
  bit          mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("we_oe_overlap", {31'd0, (!WE && !OE)}, 32'd0);
      if (CE) check_eq("dq_released", dq, 32'd0);
      if (!OE) check_eq("dq_read_clean", dq, mem[ADDR[9:0]]);
    end
  end

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    @(posedge clk); #1;
    pre_en   = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic run_round(input bit act0, input bit act1);
    bit          act [2];
    bit          done [2];
    int          order [2];
    int          exp_cyc [2];
    logic [15:0] exp_rd [2];
    logic [1:0]  exp_s;
    int          n, acc, cyc, cur, p;
    act[0] = act0;
    act[1] = act1;
    n = (act0 && act1) ? 2 : 1;
    order[0] = (act0 && act1) ? rr_next : (act0 ? 0 : 1);
    order[1] = 1 - order[0];
    acc = 0;
    for (int k = 0; k < n; k++) begin
      p = order[k];
      if (t_we[p]) begin
        if (t_be[p][0]) ref_mem[t_addr[p][9:0]][7:0]  = t_wdata[p][7:0];
        if (t_be[p][1]) ref_mem[t_addr[p][9:0]][15:8] = t_wdata[p][15:8];
        acc += LAT_WR;
      end else begin
        exp_rd[p] = ref_mem[t_addr[p][9:0]];
        acc += LAT_RD;
      end
      exp_cyc[p] = acc;
      rr_next = 1 - p;
    end
    for (int q = 0; q < 2; q++) begin
      we_i[q] = t_we[q]; addr_i[q] = t_addr[q]; wdata_i[q] = t_wdata[q];
      be_i[q] = t_be[q]; req[q] = act[q]; done[q] = 1'b0;
    end
    cyc = 1; oe_lo = 0; we_lo = 0; strobes_we = 2'b11;
    while (((act[0] && !done[0]) || (act[1] && !done[1])) && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
      cur = done[order[0]] ? order[1] : order[0];
      if (!OE) oe_lo++;
      if (!WE) begin
        we_lo++;
        strobes_we = {UB, LB};
        check_eq("dq_write", dq, t_wdata[cur]);
      end
      if (!CE) begin
        exp_s = ~t_be[cur];
        check_eq("addr_out", ADDR, t_addr[cur]);
        check_eq("byte_strobes", {UB, LB}, exp_s);
      end
      for (int q = 0; q < 2; q++) begin
        if (ack[q]) begin
          if (act[q] && !done[q]) begin
            done[q] = 1'b1;
            check_eq("ack_cycle", cyc, exp_cyc[q]);
            if (!t_we[q]) begin
              check_eq("rdata", rdata[q], exp_rd[q]);
              last_rd[q] = exp_rd[q];
              have_rd[q] = 1'b1;
            end
            req[q] = 1'b0;
          end else begin
            check_eq("ack_unexpected", ack[q], 32'd0);
          end
        end
      end
    end
    for (int q = 0; q < 2; q++) if (act[q]) check_eq("ack_seen", done[q], 32'd1);
    @(posedge clk); #1;
    for (int q = 0; q < 2; q++) if (have_rd[q]) check_eq("rdata_hold", rdata[q], last_rd[q]);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, got, last, acks, busy_fall, p, ntx, mode;
    bit dropped, seen;
    rst_n = 1'b0;
    for (int q = 0; q < 2; q++) begin
      req[q] = 1'b0; we_i[q] = 1'b0; addr_i[q] = '0; wdata_i[q] = '0; be_i[q] = '0;
      last_rd[q] = '0; have_rd[q] = 1'b0;
    end
    for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0;
    rr_next = 0;
    @(posedge clk); #1;
    mem_clr = 1'b1;
    @(posedge clk); #1;
    mem_clr = 1'b0;

    // Reset state
    check_eq("rst_strobes", {CE, OE, WE, LB, UB}, 32'h1f);
    check_eq("rst_busy", Busy, 32'd0);
    check_eq("rst_addr", ADDR, 32'd0);
    check_eq("rst_acks", {ack[1], ack[0]}, 32'd0);
    check_eq("rst_rdata", {rdata[1], rdata[0]}, 32'd0);
    check_eq("rst_dq", dq, 32'd0);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    have_rd[0] = 1'b1; have_rd[1] = 1'b1;
    @(posedge clk); #1;

    // Single read from P0
    preload(10'd3, 16'h1025);
    t_we[0] = 1'b0; t_addr[0] = 20'h00003; t_wdata[0] = 16'h0; t_be[0] = 2'b11;
    t_we[1] = 1'b0; t_addr[1] = 20'h0; t_wdata[1] = 16'h0; t_be[1] = 2'b11;
    run_round(1'b1, 1'b0);
    check_eq("read_oe_cycles", oe_lo, RW + 1);
    check_eq("read_p0_rdata", rdata[0], 32'h1025);

    // Byte write from P1
    preload(10'd5, 16'h1234);
    t_we[1] = 1'b1; t_addr[1] = 20'h00005; t_wdata[1] = 16'hABCD; t_be[1] = 2'b01;
    run_round(1'b0, 1'b1);
    check_eq("bwrite_we_cycles", we_lo, WW + 1);
    check_eq("bwrite_strobes", strobes_we, 32'b10);
    check_eq("bwrite_mem", mem[5], 32'h12CD);

    // BE=00 write completes without touching memory
    t_we[0] = 1'b1; t_addr[0] = 20'h00005; t_wdata[0] = 16'hFFFF; t_be[0] = 2'b00;
    run_round(1'b1, 1'b0);
    check_eq("be00_mem", mem[5], 32'h12CD);

    // Continuous contention: both ports hold Req high
    preload(10'd16, 16'hAAAA);
    preload(10'd32, 16'h5555);
    t_we[0] = 1'b0; t_addr[0] = 20'd16; t_be[0] = 2'b11;
    t_we[1] = 1'b0; t_addr[1] = 20'd32; t_be[1] = 2'b11;
    for (int q = 0; q < 2; q++) begin
      we_i[q] = t_we[q]; addr_i[q] = t_addr[q]; be_i[q] = t_be[q]; req[q] = 1'b1;
    end
    cyc = 1; got = 0; last = 0;
    while (got < 8 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (ack[0] || ack[1]) begin
        check_eq("rr_both_ack", {31'd0, (ack[0] && ack[1])}, 32'd0);
        check_eq("rr_port", ack[1], rr_next);
        check_eq("rr_gap", cyc - last, LAT_RD);
        p = ack[1] ? 1 : 0;
        check_eq("rr_rdata", rdata[p], ref_mem[t_addr[p][9:0]]);
        last_rd[p] = ref_mem[t_addr[p][9:0]];
        rr_next = 1 - p;
        got++;
        last = cyc;
      end
    end
    check_eq("rr_count", got, 8);
    req[0] = 1'b0; req[1] = 1'b0;
    @(posedge clk); #1;

    // Dropped request during RD
    we_i[0] = 1'b0; addr_i[0] = 20'h00003; be_i[0] = 2'b11; req[0] = 1'b1;
    cyc = 1; acks = 0; busy_fall = 0; dropped = 1'b0;
    while (cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (!OE && !dropped) begin
        req[0] = 1'b0;
        dropped = 1'b1;
      end
      if (ack[0]) acks++;
      if (!Busy && busy_fall == 0) busy_fall = cyc;
    end
    check_eq("drop_in_rd", dropped, 32'd1);
    check_eq("drop_no_ack", acks, 32'd0);
    check_eq("drop_busy_fall", busy_fall, RW + 4);
    rr_next = 1;
    have_rd[0] = 1'b0;

    // Reset during WR_PULSE
    we_i[0] = 1'b1; addr_i[0] = 20'd1008; wdata_i[0] = 16'hBEEF; be_i[0] = 2'b11; req[0] = 1'b1;
    cyc = 1; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (!WE) seen = 1'b1;
    end
    check_eq("mrst_pulse_reached", seen, 32'd1);
    #2;
    rst_n  = 1'b0;
    req[0] = 1'b0;
    #1;
    check_eq("mrst_we", WE, 32'd1);
    check_eq("mrst_ce", CE, 32'd1);
    check_eq("mrst_dq", dq, 32'd0);
    check_eq("mrst_busy", Busy, 32'd0);
    acks = 0;
    repeat (3) begin
      @(posedge clk); #1;
      acks += ack[0] + ack[1];
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      acks += ack[0] + ack[1];
    end
    check_eq("mrst_no_ack", acks, 32'd0);
    check_eq("mrst_rdata", {rdata[1], rdata[0]}, 32'd0);
    rr_next = 0;
    for (int q = 0; q < 2; q++) begin
      last_rd[q] = 16'h0;
      have_rd[q] = 1'b1;
    end

    // Randomized run
    ntx = 0;
    while (ntx < 1000) begin
      mode = $urandom_range(0, 2);
      for (int q = 0; q < 2; q++) begin
        t_we[q]    = 1'($urandom_range(0, 1));
        t_addr[q]  = 20'($urandom_range(0, 511));
        t_wdata[q] = 16'($urandom);
        t_be[q]    = 2'($urandom_range(0, 3));
      end
      run_round(mode != 1, mode != 0);
      ntx += (mode == 2) ? 2 : 1;
    end

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
